// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit datapath.
// Frame length helper keeps the top and its users in agreement.
package uart_pkg;

  typedef enum logic {
    TX_IDLE,
    TX_ACTIVE
  } tx_state_e;

  localparam int DEFAULT_CLK_DIV = 434;
  localparam int BIT_CNT_W = 4;

  function automatic int frame_bits(
    input int data_bits,
    input int parity_en,
    input int stop_bits
  );
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period divider for the TX datapath.
// Holds at the last count while the consumer is not ready to advance.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  input  logic hold,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || restart || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      if (!hold) cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_shift_datapath.sv
// UART transmit shift datapath: frames one word and serialises
// it LSB-first under the strobes of the TX control FSM.
module uart_tx_shift_datapath
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 load_TX_shift_reg,
  input  logic                 shift,
  input  logic                 clear,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 load_error
);

  localparam int FB =
    frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
  localparam logic [BIT_CNT_W-1:0] FB_CNT =
    BIT_CNT_W'(FB);

  if (FB > 15 || CLK_DIV < 2) begin : g_bad_cfg
    $error("uart_tx_shift_datapath: bad FRAME_BITS/CLK_DIV");
  end

  tx_state_e   state;
  logic [FB-1:0] sreg;
  logic [FB-1:0] frame;
  logic        accept;
  logic        tick;
  logic        advance;

  assign busy    = (state == TX_ACTIVE);
  assign accept  = load_TX_shift_reg && !busy && !clear;
  assign advance = tick && shift && (bit_count != FB_CNT);
  assign tx      = sreg[0];

  // Unused upper positions stay 1 so stop bits fall out naturally.
  always_comb begin
    frame = '1;
    frame[0] = 1'b0;
    frame[DATA_BITS:1] = tx_data;
    if (PARITY_EN != 0)
      frame[DATA_BITS+1] = (^tx_data) ^ (PARITY_ODD != 0);
  end

  uart_baud_counter #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .en     (busy),
    .restart(clear || accept),
    .hold   (!shift),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= TX_IDLE;
      sreg       <= '1;
      bit_count  <= '0;
      frame_done <= 1'b0;
      load_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      load_error <= 1'b0;
      if (clear) begin
        state     <= TX_IDLE;
        sreg      <= '1;
        bit_count <= '0;
      end else if (accept) begin
        state     <= TX_ACTIVE;
        sreg      <= frame;
        bit_count <= '0;
      end else begin
        if (load_TX_shift_reg) load_error <= 1'b1;
        if (advance) begin
          sreg      <= {1'b1, sreg[FB-1:1]};
          bit_count <= bit_count + BIT_CNT_W'(1);
          if (bit_count == FB_CNT - BIT_CNT_W'(1))
            frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_shift_datapath.sv
// Self-checking bench: timeline model for the 8N1 instance plus
// directed literal checks, including parity-enabled instances.
module tb_uart_tx_shift_datapath;

  localparam int D  = 4;
  localparam int FB = 10;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       load;
  logic       shift;
  logic       clear;

  logic [3:0] bc_a, bc_b, bc_c;
  logic tx_a, busy_a, fd_a, le_a;
  logic tx_b, busy_b, fd_b, le_b;
  logic tx_c, busy_c, fd_c, le_c;

  uart_tx_shift_datapath #(
    .CLK_DIV(D)
  ) dut_a (
    .clk(clk), .reset(reset), .tx_data(tx_data),
    .load_TX_shift_reg(load), .shift(shift),
    .clear(clear), .bit_count(bc_a), .tx(tx_a),
    .busy(busy_a), .frame_done(fd_a),
    .load_error(le_a)
  );

  uart_tx_shift_datapath #(
    .PARITY_EN(1), .PARITY_ODD(0), .CLK_DIV(D)
  ) dut_b (
    .clk(clk), .reset(reset), .tx_data(tx_data),
    .load_TX_shift_reg(load), .shift(shift),
    .clear(clear), .bit_count(bc_b), .tx(tx_b),
    .busy(busy_b), .frame_done(fd_b),
    .load_error(le_b)
  );

  uart_tx_shift_datapath #(
    .PARITY_EN(1), .PARITY_ODD(1), .CLK_DIV(D)
  ) dut_c (
    .clk(clk), .reset(reset), .tx_data(tx_data),
    .load_TX_shift_reg(load), .shift(shift),
    .clear(clear), .bit_count(bc_c), .tx(tx_c),
    .busy(busy_c), .frame_done(fd_c),
    .load_error(le_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name,
                     input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeline model for dut_a: m_pos is the number of bit-clock
  // cycles elapsed since the start bit began on the line.
  bit       started = 0;
  bit       m_busy  = 0;
  int       m_pos   = 0;
  bit       m_done  = 0;
  bit       m_lerr  = 0;
  bit [9:0] m_frame = '1;

  always @(posedge clk) begin
    started = 1;
    m_done  = 0;
    m_lerr  = 0;
    if (reset || clear) begin
      m_busy = 0;
      m_pos  = 0;
    end else if (load && !m_busy) begin
      m_busy  = 1;
      m_pos   = 0;
      m_frame = {1'b1, tx_data, 1'b0};
    end else begin
      if (load) m_lerr = 1;
      if (m_busy && m_pos < FB * D) begin
        if (!(m_pos % D == D - 1 && !shift)) begin
          m_pos++;
          if (m_pos == FB * D) m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int etx, ebc;
    if (started) begin
      etx = 1;
      if (m_busy && m_pos < FB * D)
        etx = int'(m_frame[m_pos / D]);
      ebc = m_busy ? m_pos / D : 0;
      chk("model_tx", int'(tx_a), etx);
      chk("model_busy", int'(busy_a), int'(m_busy));
      chk("model_bit_count", int'(bc_a), ebc);
      chk("model_frame_done", int'(fd_a), int'(m_done));
      chk("model_load_error", int'(le_a), int'(m_lerr));
    end
  end

  logic [15:0] cap_a, cap_b, cap_c;
  int done_at;
  int le_cnt;

  task automatic start_frame(input logic [7:0] d);
    tx_data = d;
    load    = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic send_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  // Samples each bit mid-period; p counts cycles from tx falling.
  task automatic capture(input int n, input int stall_at,
                         input int stall_len, input int err_at,
                         input int rst_at);
    cap_a = '1; cap_b = '1; cap_c = '1;
    done_at = -1;
    le_cnt  = 0;
    for (int p = 0; p < n; p++) begin
      @(negedge clk);
      if (p % D == 2 && p / D < 16) begin
        cap_a[p / D] = tx_a;
        cap_b[p / D] = tx_b;
        cap_c[p / D] = tx_c;
      end
      if (fd_a && done_at < 0) done_at = p;
      if (le_a) le_cnt++;
      if (p == stall_at) shift = 1'b0;
      if (p == stall_at + stall_len) shift = 1'b1;
      if (p == err_at) begin
        tx_data = 8'h3C;
        load    = 1'b1;
      end
      if (p == err_at + 1) load = 1'b0;
      if (p == rst_at) reset = 1'b1;
      if (p == rst_at + 1) reset = 1'b0;
    end
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b1;
    tx_data = 8'hFF;
    shift   = 1'b1;
    clear   = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", int'(tx_a), 1);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_bit_count", int'(bc_a), 0);
      chk("rst_frame_done", int'(fd_a), 0);
      chk("rst_load_error", int'(le_a), 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    load = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    send_clear();

    // 0xA5, 8N1: line must read 0,1,0,1,0,0,1,0,1,1
    start_frame(8'hA5);
    capture(44, -10, 0, -10, -10);
    chk("a5_bits", int'(cap_a[9:0]), 'h34A);
    chk("a5_done_at", done_at, 40);
    chk("a5_bit_count", int'(bc_a), 10);
    send_clear();
    @(negedge clk);
    chk("clear_busy", int'(busy_a), 0);

    // 0x07 with even (b) and odd (c) parity, 11-bit frames
    start_frame(8'h07);
    capture(44, -10, 0, -10, -10);
    chk("even_par_frame", int'(cap_b[10:0]), 'h60E);
    chk("odd_par_frame", int'(cap_c[10:0]), 'h40E);
    chk("even_par_bit", int'(cap_b[9]), 1);
    chk("odd_par_bit", int'(cap_c[9]), 0);
    @(negedge clk);
    chk("par_bit_count", int'(bc_b), 11);
    chk("odd_bit_count", int'(bc_c), 11);
    send_clear();

    // Load 0x3C mid-frame: dropped with a single error pulse
    start_frame(8'hA5);
    capture(44, -10, 0, 13, -10);
    chk("busy_load_err_cnt", le_cnt, 1);
    chk("busy_load_bits", int'(cap_a[9:0]), 'h34A);
    chk("busy_load_done_at", done_at, 40);
    send_clear();

    // Stall at the data-bit-3 tick for 6 cycles
    start_frame(8'hA5);
    capture(48, 19, 6, -10, -10);
    chk("stall_done_at", done_at, 46);
    chk("stall_bit_count", int'(bc_a), 10);
    send_clear();

    // Reset while bit_count is 5, then a clean frame
    start_frame(8'hA5);
    capture(30, -10, 0, -10, 21);
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_bit_count", int'(bc_a), 0);
    chk("midrst_tx", int'(tx_a), 1);
    @(posedge clk);
    #1;
    start_frame(8'h5A);
    capture(44, -10, 0, -10, -10);
    chk("5a_bits", int'(cap_a[9:0]), 'h2B4);
    chk("5a_done_at", done_at, 40);
    send_clear();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
